mem_port_arbiter: RTL and testbench

//  Shares one single-port unified RAM between the IF stage (instruction fetch) and the MEM stage
//  (load/store, fed from the EX/MEM register). Grants one access at a time (MEM over IF) and

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares one fixed-latency single-port RAM between IF and MEM stages.
//           Optional macro ARB_PERF_CNT_EN adds IF-wait and conflict counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  input  logic              i_if_flush,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  input  logic              i_mem_rd,
  input  logic              i_mem_wr,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_wdata,
  output logic [DATA_W-1:0] o_mem_rdata,
  output logic              o_mem_ready,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_wdata,
  input  logic [DATA_W-1:0] i_ram_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       o_perf_if_wait,
  output logic [31:0]       o_perf_conflict
`endif
);

  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_owner_mem;
  logic             r_is_wr;
  logic             r_cancel;
  logic             w_mem_req;
  logic             w_grant;
  logic             w_capture;
  logic             w_if_cancel;

  always_comb begin
    w_state_nxt = r_state;
    w_mem_req   = i_mem_rd | i_mem_wr;
    w_grant     = 1'b0;
    // The strobe cycle itself does not count down, so the capture lands
    // exactly MEM_LAT cycles after ram_en.
    w_capture   = (r_state == S_WAIT) && !o_ram_en && (r_cnt == CNT_W'(1));
    w_if_cancel = r_cancel | i_if_flush;
    case (r_state)
      S_IDLE: begin
        w_grant = w_mem_req | (i_if_req & ~i_if_flush);
        if (w_grant) w_state_nxt = S_WAIT;
      end
      S_WAIT: if (w_capture) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_owner_mem <= 1'b0;
      r_is_wr     <= 1'b0;
      r_cancel    <= 1'b0;
      o_ram_en    <= 1'b0;
      o_ram_we    <= 1'b0;
      o_ram_addr  <= '0;
      o_ram_wdata <= '0;
      o_if_ready  <= 1'b0;
      o_mem_ready <= 1'b0;
      o_if_rdata  <= '0;
      o_mem_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      o_ram_en    <= w_grant;
      o_ram_we    <= w_grant & i_mem_wr;
      o_if_ready  <= w_capture & ~r_owner_mem & ~w_if_cancel;
      o_mem_ready <= w_capture & r_owner_mem;
      if (w_grant) begin
        r_owner_mem <= w_mem_req;
        r_is_wr     <= i_mem_wr;
        r_cnt       <= CNT_W'(MEM_LAT);
        o_ram_addr  <= w_mem_req ? i_mem_addr : i_if_addr;
        o_ram_wdata <= i_mem_wdata;
      end else if (r_state == S_WAIT && !o_ram_en) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_state_nxt == S_IDLE)
        r_cancel <= 1'b0;
      else if (r_state != S_IDLE && !r_owner_mem && i_if_flush)
        r_cancel <= 1'b1;
      if (w_capture && r_owner_mem && !r_is_wr) o_mem_rdata <= i_ram_rdata;
      if (w_capture && !r_owner_mem && !w_if_cancel) o_if_rdata <= i_ram_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_perf_if_wait  <= '0;
      o_perf_conflict <= '0;
    end else begin
      if (i_if_req && !o_if_ready && o_perf_if_wait != 32'hFFFF_FFFF)
        o_perf_if_wait <= o_perf_if_wait + 32'd1;
      if (r_state == S_IDLE && i_if_req && w_mem_req && o_perf_conflict != 32'hFFFF_FFFF)
        o_perf_conflict <= o_perf_conflict + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, corner sequences and
// a ready-pulse scoreboard fed by a behavioural fixed-latency RAM.
`default_nettype none

module tb_mem_port_arbiter;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_if_req, i_if_flush, i_mem_rd, i_mem_wr;
  logic [31:0] i_if_addr, i_mem_addr, i_mem_wdata, i_ram_rdata;
  logic [31:0] o_if_rdata, o_mem_rdata, o_ram_addr, o_ram_wdata;
  logic        o_if_ready, o_mem_ready, o_ram_en, o_ram_we;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] o_perf_if_wait, o_perf_conflict;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset(reset),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
    .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready),
    .i_mem_rd(i_mem_rd), .i_mem_wr(i_mem_wr), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .o_mem_rdata(o_mem_rdata), .o_mem_ready(o_mem_ready),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata)
`ifdef ARB_PERF_CNT_EN
    , .o_perf_if_wait(o_perf_if_wait), .o_perf_conflict(o_perf_conflict)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RAM: read data appears exactly MEM_LAT cycles after the strobe,
  // filler otherwise so an early or late capture is visible.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] pipe [0:MEM_LAT-1];
  int unsigned cyc = 0;
  assign i_ram_rdata = pipe[MEM_LAT-1];

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_ram_en && o_ram_we) mem[o_ram_addr] = o_ram_wdata;
    pipe[0] <= (o_ram_en && !o_ram_we) ? ram_rd(o_ram_addr) : (32'hBAD0_0000 ^ cyc);
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_mem;
    logic [31:0] data;
  } sb_t;
  sb_t sb[$];
  logic [31:0] exp_mem_last = '0;

  task automatic push(input bit is_mem, input bit is_store, input logic [31:0] d);
    sb_t e;
    e.is_mem = is_mem;
    e.data   = (is_mem && is_store) ? exp_mem_last : d;
    if (is_mem && !is_store) exp_mem_last = d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && (o_if_ready || o_mem_ready)) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_ready: if_ready=%b mem_ready=%b expected none", o_if_ready, o_mem_ready);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_owner_mem", {31'd0, o_mem_ready}, {31'd0, e.is_mem});
        chk("sb_ready_exclusive", {31'd0, o_if_ready & o_mem_ready}, 32'd0);
        chk("sb_rdata", e.is_mem ? o_mem_rdata : o_if_rdata, e.data);
      end
    end
  end

  typedef struct {
    logic        rd, wr, ifr;
    logic [31:0] addr, wdata, exp_data;
  } vec_t;

  task automatic drive_idle();
    i_if_req = 0; i_if_flush = 0; i_mem_rd = 0; i_mem_wr = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int en_cnt = 0, en_cyc = -1, rdy_cyc = -1;
    logic we_s = 0;
    logic [31:0] a_s = '0, d_s = '0;
    @(negedge clk);
    i_mem_rd = v.rd; i_mem_wr = v.wr; i_if_req = v.ifr;
    i_mem_addr = v.addr; i_if_addr = v.addr; i_mem_wdata = v.wdata;
    push(v.rd | v.wr, v.wr, v.exp_data);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (o_ram_en) begin
        en_cnt++; en_cyc = c; we_s = o_ram_we; a_s = o_ram_addr; d_s = o_ram_wdata;
      end
      if ((o_if_ready || o_mem_ready) && rdy_cyc < 0) begin
        rdy_cyc = c;
        drive_idle();
      end
    end
    chk($sformatf("v%0d_en_count", idx), en_cnt, 1);
    chk($sformatf("v%0d_en_cycle", idx), en_cyc, 1);
    chk($sformatf("v%0d_we", idx), {31'd0, we_s}, {31'd0, v.wr});
    chk($sformatf("v%0d_addr", idx), a_s, v.addr);
    if (v.wr) chk($sformatf("v%0d_wdata", idx), d_s, v.wdata);
    chk($sformatf("v%0d_ready_cycle", idx), rdy_cyc, MEM_LAT + 2);
  endtask

  vec_t vecs[7];
  int en_cycs[$];
  int rdy_if, rdy_mem;
  logic [31:0] saved;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_1234, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'h0000_1234};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0,         32'hCAFE_F00D};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0204, 32'h0,         32'hA5A5_0204};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h5A5A_FFFC};
    mem[32'h40] = 32'hDEAD_BEEF;
    mem[32'h80] = 32'h0BAD_F00D;
    for (int i = 0; i < MEM_LAT; i++) pipe[i] = '0;
    drive_idle();
    i_if_addr = '0; i_mem_addr = '0; i_mem_wdata = '0;

    reset = 1;
    #1;
    chk("rst_ram_en", {31'd0, o_ram_en}, 32'd0);
    chk("rst_ram_we", {31'd0, o_ram_we}, 32'd0);
    chk("rst_ready", {30'd0, o_if_ready, o_mem_ready}, 32'd0);
    chk("rst_ram_addr", o_ram_addr, 32'd0);
    chk("rst_rdata", o_if_rdata | o_mem_rdata, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;

    // Simultaneous IF and MEM requests: MEM first, IF held through MEM's DONE.
    @(negedge clk);
    i_mem_rd = 1; i_mem_addr = 32'h80; i_if_req = 1; i_if_addr = 32'h40;
    push(1, 0, 32'h0BAD_F00D);
    push(0, 0, 32'hDEAD_BEEF);
    rdy_if = -1; rdy_mem = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (o_ram_en) en_cycs.push_back(c);
      if (o_ram_en && c > 1) chk("cf_if_addr", o_ram_addr, 32'h40);
      if (o_mem_ready && rdy_mem < 0) begin rdy_mem = c; i_mem_rd = 0; end
      if (o_if_ready && rdy_if < 0) begin rdy_if = c; i_if_req = 0; end
    end
    chk("cf_en_count", en_cycs.size(), 2);
    if (en_cycs.size() == 2) begin
      chk("cf_en_mem_cycle", en_cycs[0], 1);
      chk("cf_en_if_cycle", en_cycs[1], 6);
    end
    chk("cf_mem_ready_cycle", rdy_mem, 4);
    chk("cf_if_ready_cycle", rdy_if, 9);
`ifdef ARB_PERF_CNT_EN
    chk("perf_conflict", o_perf_conflict, 32'd1);
    chk("perf_if_wait", o_perf_if_wait, 32'd9);
`endif

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Flush of a granted fetch; a new fetch held through DONE waits for IDLE.
    en_cycs.delete();
    rdy_if = -1;
    saved = o_if_rdata;
    @(negedge clk);
    i_if_req = 1; i_if_addr = 32'h40;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (o_ram_en) en_cycs.push_back(c);
      if (o_if_ready && rdy_if < 0) begin rdy_if = c; i_if_req = 0; end
      if (c == 2) begin i_if_flush = 1; i_if_req = 0; end
      if (c == 3) begin
        i_if_flush = 0; i_if_req = 1; i_if_addr = 32'h204;
        push(0, 0, 32'hA5A5_0204);
      end
      if (c == 5) chk("fl_rdata_kept", o_if_rdata, saved);
    end
    chk("fl_en_count", en_cycs.size(), 2);
    if (en_cycs.size() == 2) chk("fl_regrant_cycle", en_cycs[1], 6);
    chk("fl_ready_cycle", rdy_if, 9);

    // Asynchronous reset in the middle of a MEM access.
    @(negedge clk);
    i_mem_rd = 1; i_mem_addr = 32'h80;
    repeat (2) @(negedge clk);
    drive_idle();
    #2 reset = 1;
    #1;
    chk("arst_ram_addr", o_ram_addr, 32'd0);
    chk("arst_rdata", o_if_rdata | o_mem_rdata, 32'd0);
    chk("arst_ready", {30'd0, o_if_ready, o_mem_ready}, 32'd0);
    @(negedge clk);
    reset = 0;
    rdy_mem = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_mem_ready || o_if_ready || o_ram_en) rdy_mem++;
    end
    chk("arst_no_activity", rdy_mem, 0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
